// File: rtl/step_pkg.sv
// Shared types and defaults for the stepper pulse generator.
//   state_e      : move FSM states
//   Def*         : default parameter values
//   max_u        : max of two unsigned ints, used to size the shared timer
package step_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StWaitTick,
      StPulse,
      StDone
   } state_e;

   localparam int unsigned DefCntW     = 32;
   localparam int unsigned DefPulseW   = 4;
   localparam int unsigned DefDirSetup = 8;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/step_pulse_gen_if.sv
// Command, rate and driver-side signals of one stepper axis.
//   master : command issuer / rate source (drives cmd_*, abort, rate_en)
//   slave  : step_pulse_gen (drives cmd_ready, step, dir, busy, steps_left, done, overrun)
interface step_pulse_gen_if #(
   parameter int unsigned CNT_W = step_pkg::DefCntW
) ();

   logic             rate_en;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [CNT_W-1:0] cmd_steps;
   logic             cmd_dir;
   logic             abort;
   logic             step;
   logic             dir;
   logic             busy;
   logic [CNT_W-1:0] steps_left;
   logic             done;
   logic             overrun;

   modport master (
      output rate_en, cmd_valid, cmd_steps, cmd_dir, abort,
      input  cmd_ready, step, dir, busy, steps_left, done, overrun
   );

   modport slave (
      input  rate_en, cmd_valid, cmd_steps, cmd_dir, abort,
      output cmd_ready, step, dir, busy, steps_left, done, overrun
   );

endinterface

// File: rtl/rise_detect.sv
// Rising-edge detector.
//   clk, rst : clock, synchronous active-high reset
//   in       : level input (same clock domain)
//   pulse    : high for the cycle where in=1 and its registered copy is 0
module rise_detect (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic pulse
);

   logic in_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         in_q <= 1'b0;
      end else begin
         in_q <= in;
      end
   end

   assign pulse = in & ~in_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Stepper-axis pulse generator. Accepts one move command at a time, settles dir,
// then emits one fixed-width step pulse per rising edge of rate_en until the
// requested count is exhausted or the move is aborted.
//   clk, rst : clock, synchronous active-high reset
//   bus      : step_pulse_gen_if slave (command handshake, rate_en, driver outputs)
module step_pulse_gen
   import step_pkg::*;
#(
   parameter int unsigned CNT_W     = DefCntW,
   parameter int unsigned PULSE_W   = DefPulseW,
   parameter int unsigned DIR_SETUP = DefDirSetup
) (
   input logic             clk,
   input logic             rst,
   step_pulse_gen_if.slave bus
);

   // One timer serves both the dir-setup wait and the pulse width.
   localparam int unsigned TmrMax = max_u(PULSE_W, DIR_SETUP) - 1;
   localparam int unsigned TmrW   = (TmrMax < 2) ? 1 : $clog2(TmrMax + 1);
   localparam logic [TmrW-1:0] PulseLoad = TmrW'(PULSE_W - 1);
   localparam logic [TmrW-1:0] SetupLoad = TmrW'(DIR_SETUP - 1);

   state_e           state_q, state_d;
   logic [TmrW-1:0]  tmr_q, tmr_d;
   logic [CNT_W-1:0] steps_left_q, steps_left_d;
   logic             dir_q, dir_d;
   logic             overrun_q, overrun_d;
   logic             abort_q, abort_d;
   logic             tick;
   logic             tmr_zero;

   rise_detect u_rise_detect (
      .clk   (clk),
      .rst   (rst),
      .in    (bus.rate_en),
      .pulse (tick)
   );

   assign tmr_zero = (tmr_q == '0);

   always_comb begin
      state_d      = state_q;
      tmr_d        = tmr_q;
      steps_left_d = steps_left_q;
      dir_d        = dir_q;
      overrun_d    = overrun_q;
      abort_d      = abort_q;

      unique case (state_q)
         StIdle: begin
            if (bus.cmd_valid) begin
               dir_d        = bus.cmd_dir;
               steps_left_d = bus.cmd_steps;
               overrun_d    = 1'b0;
               abort_d      = 1'b0;
               if (bus.cmd_steps == '0) begin
                  state_d = StDone;
               end else begin
                  state_d = StSetup;
                  tmr_d   = SetupLoad;
               end
            end
         end

         // Ticks here are deliberately discarded, not queued.
         StSetup: begin
            if (bus.abort) begin
               state_d = StIdle;
            end else if (tmr_zero) begin
               state_d = StWaitTick;
            end else begin
               tmr_d = tmr_q - TmrW'(1);
            end
         end

         // Abort beats a coincident tick.
         StWaitTick: begin
            if (bus.abort) begin
               state_d = StIdle;
            end else if (tick) begin
               state_d = StPulse;
               tmr_d   = PulseLoad;
               abort_d = 1'b0;
               if (steps_left_q != '0) begin
                  steps_left_d = steps_left_q - CNT_W'(1);
               end
            end
         end

         // Abort is remembered so the pulse always completes its full width.
         StPulse: begin
            if (tick) begin
               overrun_d = 1'b1;
            end
            if (bus.abort) begin
               abort_d = 1'b1;
            end
            if (tmr_zero) begin
               if (abort_q || bus.abort) begin
                  state_d = StIdle;
               end else if (steps_left_q == '0) begin
                  state_d = StDone;
               end else begin
                  state_d = StWaitTick;
               end
            end else begin
               tmr_d = tmr_q - TmrW'(1);
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         tmr_q        <= '0;
         steps_left_q <= '0;
         dir_q        <= 1'b0;
         overrun_q    <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         steps_left_q <= steps_left_d;
         dir_q        <= dir_d;
         overrun_q    <= overrun_d;
         abort_q      <= abort_d;
      end
   end

   assign bus.cmd_ready  = (state_q == StIdle);
   assign bus.busy       = (state_q != StIdle);
   assign bus.step       = (state_q == StPulse);
   assign bus.done       = (state_q == StDone);
   assign bus.dir        = dir_q;
   assign bus.steps_left = steps_left_q;
   assign bus.overrun    = overrun_q;

endmodule
